// File: rtl/layer_sequencer.sv
// rtl/layer_sequencer.sv - multi-layer scheduler driving the single-layer control engine
module layer_sequencer #(
    parameter int MAX_LAYERS = 8,
    parameter int IDX_W      = 3,
    parameter int TIMEOUT    = 65535,
    parameter int ACK_WINDOW = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_we,
    input  logic [IDX_W-1:0] cfg_addr,
    input  logic [23:0]      cfg_data,
    input  logic [IDX_W:0]   num_layers,
    input  logic             run,
    input  logic             abort,
    input  logic             ctrl_idle,
    output logic             ctrl_start,
    output logic [8:0]       weight_base,
    output logic [7:0]       alpha_base,
    output logic [6:0]       out_count,
    output logic             act_src_bank,
    output logic             act_dst_bank,
    output logic [IDX_W-1:0] layer_idx,
    output logic             busy,
    output logic             done,
    output logic             error
);

    localparam int ACK_W  = $clog2(ACK_WINDOW + 1);
    localparam int WAIT_W = $clog2(TIMEOUT + 1);
    localparam logic [IDX_W:0] MAX_L = (IDX_W+1)'(MAX_LAYERS);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_START, S_ACK, S_WAIT, S_NEXT, S_FIN
    } state_t;

    state_t              state_q;
    logic [23:0]         table_q [MAX_LAYERS];
    logic [IDX_W:0]      nl_q;
    logic [IDX_W-1:0]    idx_q;
    logic                src_q;
    logic [8:0]          wb_q;
    logic [7:0]          ab_q;
    logic [6:0]          oc_q;
    logic                start_q;
    logic                done_q;
    logic                err_q;
    logic                abort_q;
    logic [ACK_W-1:0]    ack_cnt_q;
    logic [WAIT_W-1:0]   wait_cnt_q;

    // Table survives reset; host only rewrites it between runs.
    always_ff @(posedge clk) begin
        if (cfg_we && state_q == S_IDLE) begin
            table_q[cfg_addr] <= cfg_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            nl_q       <= '0;
            idx_q      <= '0;
            src_q      <= 1'b0;
            wb_q       <= '0;
            ab_q       <= '0;
            oc_q       <= '0;
            start_q    <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            abort_q    <= 1'b0;
            ack_cnt_q  <= '0;
            wait_cnt_q <= '0;
        end else begin
            start_q <= 1'b0;
            done_q  <= 1'b0;
            if (state_q != S_IDLE && abort) begin
                abort_q <= 1'b1;
            end
            case (state_q)
                S_IDLE: begin
                    if (run) begin
                        nl_q    <= (num_layers > MAX_L) ? MAX_L : num_layers;
                        idx_q   <= '0;
                        src_q   <= 1'b0;
                        err_q   <= 1'b0;
                        abort_q <= 1'b0;
                        state_q <= (num_layers == '0) ? S_FIN : S_LOAD;
                    end
                end
                S_LOAD: begin
                    {wb_q, ab_q, oc_q} <= table_q[idx_q];
                    start_q            <= 1'b1;
                    state_q            <= S_START;
                end
                S_START: begin
                    ack_cnt_q <= '0;
                    state_q   <= S_ACK;
                end
                S_ACK: begin
                    if (!ctrl_idle) begin
                        wait_cnt_q <= '0;
                        state_q    <= S_WAIT;
                    end else if (ack_cnt_q == ACK_W'(ACK_WINDOW - 1)) begin
                        err_q   <= 1'b1;
                        state_q <= S_FIN;
                    end else begin
                        ack_cnt_q <= ack_cnt_q + 1'b1;
                    end
                end
                S_WAIT: begin
                    if (ctrl_idle) begin
                        state_q <= S_NEXT;
                    end else if (wait_cnt_q == WAIT_W'(TIMEOUT - 1)) begin
                        err_q   <= 1'b1;
                        state_q <= S_FIN;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 1'b1;
                    end
                end
                S_NEXT: begin
                    src_q <= ~src_q;
                    // An abort arriving in this very cycle still stops the walk.
                    if ((IDX_W+1)'(idx_q) + (IDX_W+1)'(1) == nl_q || abort_q || abort) begin
                        state_q <= S_FIN;
                    end else begin
                        idx_q   <= idx_q + 1'b1;
                        state_q <= S_LOAD;
                    end
                end
                S_FIN: begin
                    done_q  <= 1'b1;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign ctrl_start   = start_q;
    assign weight_base  = wb_q;
    assign alpha_base   = ab_q;
    assign out_count    = oc_q;
    assign act_src_bank = src_q;
    assign act_dst_bank = ~src_q;
    assign layer_idx    = idx_q;
    assign busy         = (state_q != S_IDLE);
    assign done         = done_q;
    assign error        = err_q;

endmodule

// File: tb/tb_layer_sequencer.sv
// tb/tb_layer_sequencer.sv - self-checking bench for layer_sequencer
module tb_layer_sequencer;
    localparam int MAXL = 8;
    localparam int IDXW = 3;
    localparam int TOUT = 100;
    localparam int ACKW = 4;

    logic clk = 1'b0;
    logic rst;
    logic cfg_we = 1'b0;
    logic [IDXW-1:0] cfg_addr = '0;
    logic [23:0] cfg_data = '0;
    logic [IDXW:0] num_layers = '0;
    logic run = 1'b0, abort = 1'b0, ctrl_idle = 1'b1;
    logic ctrl_start, act_src_bank, act_dst_bank, busy, done, error;
    logic [8:0] weight_base;
    logic [7:0] alpha_base;
    logic [6:0] out_count;
    logic [IDXW-1:0] layer_idx;

    layer_sequencer #(.MAX_LAYERS(MAXL), .IDX_W(IDXW), .TIMEOUT(TOUT), .ACK_WINDOW(ACKW)) dut (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .num_layers(num_layers), .run(run), .abort(abort), .ctrl_idle(ctrl_idle),
        .ctrl_start(ctrl_start), .weight_base(weight_base), .alpha_base(alpha_base),
        .out_count(out_count), .act_src_bank(act_src_bank), .act_dst_bank(act_dst_bank),
        .layer_idx(layer_idx), .busy(busy), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Reference model: walks a run as a timeline of clock edges.
    bit m_busy, m_start, m_done, m_err, m_src, m_ab, s_idle;
    logic [IDXW-1:0] m_idx;
    logic [8:0] m_wb;
    logic [7:0] m_al;
    logic [6:0] m_oc;
    logic [23:0] m_tab [MAXL];

    task automatic m_reset();
        m_busy = 0; m_start = 0; m_done = 0; m_err = 0; m_src = 0;
        m_idx = '0; m_wb = '0; m_al = '0; m_oc = '0;
    endtask

    task automatic step(output bit ok);
        @(posedge clk or posedge rst);
        if (rst) begin
            m_reset();
            ok = 0;
        end else begin
            ok = 1;
            s_idle = ctrl_idle;
            if (abort) m_ab = 1;
        end
    endtask

    task automatic run_job();
        bit ok, fin, got;
        int n, c;
        n = (int'(num_layers) > MAXL) ? MAXL : int'(num_layers);
        m_busy = 1; m_err = 0; m_idx = '0; m_src = 0; m_ab = 0;
        fin = (n == 0);
        while (!fin) begin
            step(ok); if (!ok) return;
            {m_wb, m_al, m_oc} = m_tab[m_idx];
            m_start = 1;
            step(ok); if (!ok) return;
            m_start = 0;
            c = 0; got = 0;
            while (!got && !fin) begin
                step(ok); if (!ok) return;
                if (!s_idle) got = 1;
                else if (++c == ACKW) begin m_err = 1; fin = 1; end
            end
            if (fin) break;
            c = 0; got = 0;
            while (!got && !fin) begin
                step(ok); if (!ok) return;
                if (s_idle) got = 1;
                else if (++c == TOUT) begin m_err = 1; fin = 1; end
            end
            if (fin) break;
            step(ok); if (!ok) return;
            m_src = !m_src;
            if (int'(m_idx) == n - 1 || m_ab) fin = 1;
            else m_idx = m_idx + 1'b1;
        end
        step(ok); if (!ok) return;
        m_done = 1;
        m_busy = 0;
    endtask

    initial begin
        for (int i = 0; i < MAXL; i++) m_tab[i] = '0;
        m_reset();
        forever begin
            @(posedge clk or posedge rst);
            m_done = 0;
            if (rst) m_reset();
            else begin
                if (cfg_we) m_tab[cfg_addr] = cfg_data;
                if (run) run_job();
            end
        end
    end

    // Engine stand-in: idle drops 2 cycles after start; mode picks how it recovers.
    int eng_mode = 0;
    int eng_t = -1;
    initial begin
        bit st, r;
        forever begin
            @(negedge clk);
            st = ctrl_start; r = rst;
            @(posedge clk);
            if (r) eng_t = -1;
            else if (st) eng_t = 0;
            else if (eng_t >= 0) eng_t++;
            #2;
            case (eng_mode)
                0: ctrl_idle = !(eng_t >= 1 && eng_t <= 50);
                1: ctrl_idle = 1'b1;
                default: ctrl_idle = !(eng_t >= 1);
            endcase
        end
    end

    int cyc_n = 0, n_start, n_done, n_busy, run_cyc, done_cyc, first_start_cyc;
    logic [8:0] wb_l1;
    logic [7:0] al_l1;
    logic [6:0] oc_l1;
    logic [7:0] bank_seq;

    task automatic clr_mon();
        n_start = 0; n_done = 0; n_busy = 0; run_cyc = -1; done_cyc = -1;
        first_start_cyc = -1; bank_seq = '0; wb_l1 = '0; al_l1 = '0; oc_l1 = '0;
    endtask

    initial begin
        clr_mon();
        forever begin
            @(negedge clk);
            cyc_n++;
            chk("ctrl_start", ctrl_start, m_start);
            chk("done", done, m_done);
            chk("busy", busy, m_busy);
            chk("error", error, m_err);
            chk("layer_idx", layer_idx, m_idx);
            chk("act_src_bank", act_src_bank, m_src);
            chk("act_dst_bank", act_dst_bank, !m_src);
            chk("weight_base", weight_base, m_wb);
            chk("alpha_base", alpha_base, m_al);
            chk("out_count", out_count, m_oc);
            if (run && !busy) run_cyc = cyc_n;
            if (busy) n_busy++;
            if (done) begin n_done++; done_cyc = cyc_n; end
            if (ctrl_start) begin
                n_start++;
                if (first_start_cyc < 0) first_start_cyc = cyc_n;
                bank_seq = {bank_seq[6:0], act_src_bank};
                if (layer_idx == 1) begin wb_l1 = weight_base; al_l1 = alpha_base; oc_l1 = out_count; end
            end
        end
    end

    task automatic cyc(input int n = 1);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic wr(input logic [IDXW-1:0] a, input logic [8:0] wb, input logic [7:0] al, input logic [6:0] oc);
        cfg_we = 1; cfg_addr = a; cfg_data = {wb, al, oc};
        cyc();
        cfg_we = 0;
    endtask

    task automatic go(input logic [IDXW:0] n);
        num_layers = n; run = 1;
        cyc();
        run = 0;
    endtask

    task automatic wait_done(input int budget, input string nm);
        int k = 0;
        while (n_done == 0 && k < budget) begin cyc(); k++; end
        chk({nm, " done seen"}, n_done != 0, 1);
        cyc(2);
    endtask

    task automatic scen1(input string nm);
        clr_mon(); eng_mode = 0;
        go(3);
        wait_done(400, nm);
        chk({nm, " starts"}, n_start, 3);
        chk({nm, " wb_l1"}, wb_l1, 9'h040);
        chk({nm, " al_l1"}, al_l1, 8'h20);
        chk({nm, " oc_l1"}, oc_l1, 7'd16);
        chk({nm, " bank_seq"}, bank_seq, 8'b010);
        chk({nm, " dones"}, n_done, 1);
        chk({nm, " src_end"}, act_src_bank, 1);
        chk({nm, " error"}, error, 0);
    endtask

    initial begin
        int k;
        rst = 1'b1;
        cyc(3);
        chk("rst busy", busy, 0);
        chk("rst done", done, 0);
        chk("rst error", error, 0);
        chk("rst layer_idx", layer_idx, 0);
        rst = 1'b0;
        cyc(2);
        wr(0, 9'h100, 8'h10, 7'd8);
        wr(1, 9'h040, 8'h20, 7'd16);
        wr(2, 9'h1FF, 8'hFF, 7'd127);
        for (int i = 3; i < MAXL; i++) wr(i[IDXW-1:0], 9'(i * 17), 8'(i * 3), 7'(i));
        cyc(2);

        scen1("s1");

        clr_mon();
        go(0);
        cyc(5);
        chk("s2 starts", n_start, 0);
        chk("s2 done_latency", done_cyc - run_cyc, 2);
        chk("s2 busy_cycles", n_busy, 1);
        chk("s2 dones", n_done, 1);

        clr_mon();
        go(4);
        k = 0;
        while (n_start < 2 && k < 300) begin cyc(); k++; end
        cyc(10);
        abort = 1; cyc(); abort = 0;
        wait_done(300, "s3");
        chk("s3 starts", n_start, 2);
        chk("s3 dones", n_done, 1);
        chk("s3 layer_idx", layer_idx, 1);

        clr_mon(); eng_mode = 1;
        go(2);
        wait_done(50, "s4");
        chk("s4 error", error, 1);
        chk("s4 done_latency", done_cyc - first_start_cyc, ACKW + 2);
        chk("s4 starts", n_start, 1);
        clr_mon(); eng_mode = 0;
        go(1);
        chk("s4 error_cleared", error, 0);
        wait_done(100, "s4b");
        chk("s4b error", error, 0);

        clr_mon(); eng_mode = 2;
        go(3);
        wait_done(300, "s5");
        chk("s5 error", error, 1);
        chk("s5 done_latency", done_cyc - first_start_cyc, TOUT + 4);
        chk("s5 busy_after", busy, 0);
        chk("s5 starts", n_start, 1);
        eng_mode = 0;
        cyc(3);

        clr_mon();
        cfg_we = 1; cfg_addr = 0; cfg_data = {9'h0AA, 8'h55, 7'h11};
        go(1);
        cfg_we = 0;
        wait_done(100, "wr_run");
        chk("wr_run weight_base", weight_base, 9'h0AA);
        chk("wr_run alpha_base", alpha_base, 8'h55);
        chk("wr_run out_count", out_count, 7'h11);

        clr_mon();
        abort = 1; cyc(); abort = 0;
        go(4'd15);
        wait_done(700, "clamp");
        chk("clamp starts", n_start, MAXL);
        chk("clamp layer_idx", layer_idx, MAXL - 1);
        chk("clamp src_end", act_src_bank, 0);

        clr_mon();
        go(3);
        k = 0;
        while (n_start < 3 && k < 300) begin cyc(); k++; end
        cyc(10);
        rst = 1'b1;
        #1;
        chk("s6 busy", busy, 0);
        chk("s6 ctrl_start", ctrl_start, 0);
        chk("s6 layer_idx", layer_idx, 0);
        chk("s6 weight_base", weight_base, 0);
        chk("s6 src", act_src_bank, 0);
        chk("s6 error", error, 0);
        cyc(2);
        rst = 1'b0;
        cyc(4);
        chk("s6 no_done", n_done, 0);
        scen1("s6_rerun");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
